// File: rtl/tx_byte_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tx_byte_scheduler_if : host-side bus of the transmit scheduler.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface tx_byte_scheduler_if #(
    parameter int DEPTH = 8
) ();
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic               WrEn;
    logic [7:0]         WrData;
    logic               Full;
    logic               Empty;
    logic [c_cnt_w-1:0] Count;
    logic               Overflow;
    logic               ClrOvf;
    logic               TxEnable;
    logic               Send;
    logic [7:0]         PDin;
    logic               Busy;

    modport master (
        output WrEn, WrData, ClrOvf, TxEnable,
        input  Full, Empty, Count, Overflow, Send, PDin, Busy
    );

    modport slave (
        input  WrEn, WrData, ClrOvf, TxEnable,
        output Full, Empty, Count, Overflow, Send, PDin, Busy
    );
endinterface
`default_nettype wire

// File: rtl/tx_byte_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tx_byte_scheduler : byte FIFO feeding paced Send pulses to the   |
// | serial transmitter.                              Rev 1.0         |
// +------------------------------------------------------------------+
module tx_byte_scheduler #(
    parameter int DEPTH        = 8,
    parameter int FRAME_CYCLES = 12
) (
    input  wire logic          Clk,
    input  wire logic          Rst_n,
    tx_byte_scheduler_if.slave bus
);
    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam int c_gap_w  = $clog2(FRAME_CYCLES);
    localparam logic [c_gap_w-1:0] c_gap_init = c_gap_w'(FRAME_CYCLES - 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    logic [7:0]          mem_q [DEPTH];
    logic [c_addr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_addr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]  count_q,  count_d;
    logic                ovf_q,    ovf_d;
    state_t              state_q,  state_d;
    logic                send_q,   send_d;
    logic [7:0]          pdin_q,   pdin_d;
    logic [c_gap_w-1:0]  gap_q,    gap_d;

    logic w_full;
    logic w_empty;
    logic w_wr_ok;
    logic w_pop;

    assign w_full  = (count_q == c_cnt_w'(DEPTH));
    assign w_empty = (count_q == '0);
    // Full is judged on the pre-edge count, so a simultaneous pop does not rescue a write.
    assign w_wr_ok = bus.WrEn && !w_full;

    always_comb begin
        state_d = state_q;
        send_d  = 1'b0;
        pdin_d  = pdin_q;
        gap_d   = gap_q;
        w_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.TxEnable && !w_empty) begin
                    send_d  = 1'b1;
                    pdin_d  = mem_q[rd_ptr_q];
                    w_pop   = 1'b1;
                    gap_d   = c_gap_init;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                gap_d = gap_q - c_gap_w'(1);
                if (gap_q == c_gap_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (w_wr_ok) begin
            wr_ptr_d = wr_ptr_q + c_addr_w'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_addr_w'(1);
        end
        case ({w_wr_ok, w_pop})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase
        // A dropped write wins over a clear arriving in the same cycle.
        if (bus.WrEn && w_full) begin
            ovf_d = 1'b1;
        end else if (bus.ClrOvf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            send_q   <= 1'b0;
            pdin_q   <= 8'h00;
            gap_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            send_q   <= send_d;
            pdin_q   <= pdin_d;
            gap_q    <= gap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_wr_ok) begin
            mem_q[wr_ptr_q] <= bus.WrData;
        end
    end

    assign bus.Full     = w_full;
    assign bus.Empty    = w_empty;
    assign bus.Count    = count_q;
    assign bus.Overflow = ovf_q;
    assign bus.Send     = send_q;
    assign bus.PDin     = pdin_q;
    assign bus.Busy     = (state_q == WAIT);

endmodule
`default_nettype wire

// File: tb/tb_tx_byte_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_tx_byte_scheduler : directed bench with serial tx/rx models.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_tx_byte_scheduler;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

    tx_byte_scheduler_if #(.DEPTH(8)) bus ();

    tx_byte_scheduler #(
        .DEPTH        (8),
        .FRAME_CYCLES (12)
    ) u_dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Serial transmitter model: start '1' then 8 data bits MSB first.
    logic [8:0] tx_sh;
    logic [3:0] tx_cnt;
    logic       tx_line;
    assign tx_line = (tx_cnt != 4'd0) ? tx_sh[8] : 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh  <= '0;
            tx_cnt <= '0;
        end else if (bus.Send) begin
            tx_sh  <= {1'b1, bus.PDin};
            tx_cnt <= 4'd9;
        end else if (tx_cnt != 4'd0) begin
            tx_sh  <= {tx_sh[7:0], 1'b0};
            tx_cnt <= tx_cnt - 4'd1;
        end
    end

    logic [7:0] rx_sh;
    logic [3:0] rx_cnt;
    logic       pd_ready;
    logic [7:0] pd_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh    <= '0;
            rx_cnt   <= '0;
            pd_ready <= 1'b0;
            pd_out   <= '0;
        end else begin
            pd_ready <= 1'b0;
            if (rx_cnt == 4'd0) begin
                if (tx_line) rx_cnt <= 4'd8;
            end else begin
                rx_sh  <= {rx_sh[6:0], tx_line};
                rx_cnt <= rx_cnt - 4'd1;
                if (rx_cnt == 4'd1) begin
                    pd_ready <= 1'b1;
                    pd_out   <= {rx_sh[6:0], tx_line};
                end
            end
        end
    end

    int         sq_cyc[$];
    logic [7:0] sq_data[$];
    logic [7:0] rq[$];
    logic       prev_send;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.Send) begin
            check("send_not_back_to_back", 32'(prev_send), 32'd0);
            sq_cyc.push_back(cyc);
            sq_data.push_back(bus.PDin);
        end
        prev_send <= bus.Send;
        if (pd_ready) rq.push_back(pd_out);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] b);
        bus.WrEn   = 1'b1;
        bus.WrData = b;
        tick();
        bus.WrEn   = 1'b0;
    endtask

    initial begin
        int         n;
        int         mx;
        logic [7:0] exp5[20];

        total = 0;
        bad = 0;
        cyc = 0;
        prev_send = 1'b0;
        rst_n = 1'b0;
        bus.WrEn = 1'b0;
        bus.WrData = 8'h00;
        bus.ClrOvf = 1'b0;
        bus.TxEnable = 1'b1;
        tick(3);

        check("rst_count", 32'(bus.Count), 32'd0);
        check("rst_empty", 32'(bus.Empty), 32'd1);
        check("rst_full", 32'(bus.Full), 32'd0);
        check("rst_ovf", 32'(bus.Overflow), 32'd0);
        check("rst_send", 32'(bus.Send), 32'd0);
        check("rst_pdin", 32'(bus.PDin), 32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single byte: Send one edge after the write lands.
        wr(8'hA5);
        check("t1_count_after_wr", 32'(bus.Count), 32'd1);
        check("t1_send_early", 32'(bus.Send), 32'd0);
        tick();
        check("t1_send", 32'(bus.Send), 32'd1);
        check("t1_pdin", 32'(bus.PDin), 32'hA5);
        check("t1_empty", 32'(bus.Empty), 32'd1);
        n = 0;
        repeat (20) begin
            if (bus.Busy) n++;
            tick();
        end
        check("t1_busy_cycles", 32'(n), 32'd11);
        check("t1_send_count", 32'(sq_cyc.size()), 32'd1);

        // Burst of five: spacing 12, first byte leaves early.
        sq_cyc.delete();
        sq_data.delete();
        mx = 0;
        for (int i = 1; i <= 5; i++) begin
            bus.WrEn = 1'b1;
            bus.WrData = 8'(i);
            tick();
            if (int'(bus.Count) > mx) mx = int'(bus.Count);
        end
        bus.WrEn = 1'b0;
        repeat (60) begin
            tick();
            if (int'(bus.Count) > mx) mx = int'(bus.Count);
        end
        check("t2_max_count", 32'(mx), 32'd4);
        check("t2_send_count", 32'(sq_cyc.size()), 32'd5);
        if (sq_cyc.size() == 5) begin
            for (int i = 0; i < 5; i++) check("t2_pdin", 32'(sq_data[i]), 32'(i + 1));
            for (int i = 1; i < 5; i++) check("t2_spacing", 32'(sq_cyc[i] - sq_cyc[i-1]), 32'd12);
        end

        // Fill with transmit held off, overflow, clear, drain.
        bus.TxEnable = 1'b0;
        for (int i = 0; i < 8; i++) wr(8'(8'h10 + i));
        check("t3_full", 32'(bus.Full), 32'd1);
        check("t3_count8", 32'(bus.Count), 32'd8);
        check("t3_no_ovf_yet", 32'(bus.Overflow), 32'd0);
        wr(8'h99);
        check("t3_ovf", 32'(bus.Overflow), 32'd1);
        check("t3_count_hold", 32'(bus.Count), 32'd8);
        bus.ClrOvf = 1'b1;
        tick();
        bus.ClrOvf = 1'b0;
        check("t3_ovf_clr", 32'(bus.Overflow), 32'd0);
        sq_cyc.delete();
        sq_data.delete();
        bus.TxEnable = 1'b1;
        tick(110);
        check("t3_send_count", 32'(sq_data.size()), 32'd8);
        if (sq_data.size() == 8)
            for (int i = 0; i < 8; i++) check("t3_pdin", 32'(sq_data[i]), 32'(8'h10 + i));
        check("t3_empty", 32'(bus.Empty), 32'd1);

        // Async reset mid-gap with three bytes queued.
        for (int i = 0; i < 4; i++) begin
            bus.WrEn = 1'b1;
            bus.WrData = 8'(8'h41 + i);
            tick();
        end
        bus.WrEn = 1'b0;
        tick(2);
        check("t4_count_pre", 32'(bus.Count), 32'd3);
        check("t4_busy_pre", 32'(bus.Busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t4_send_rst", 32'(bus.Send), 32'd0);
        check("t4_busy_rst", 32'(bus.Busy), 32'd0);
        check("t4_count_rst", 32'(bus.Count), 32'd0);
        check("t4_empty_rst", 32'(bus.Empty), 32'd1);
        check("t4_pdin_rst", 32'(bus.PDin), 32'd0);
        tick();
        rst_n = 1'b1;
        sq_cyc.delete();
        sq_data.delete();
        tick(30);
        check("t4_no_send_after_rst", 32'(sq_data.size()), 32'd0);
        wr(8'h77);
        tick(20);
        check("t4_send_after_wr", 32'(sq_data.size()), 32'd1);
        if (sq_data.size() == 1) check("t4_pdin", 32'(sq_data[0]), 32'h77);

        // Twenty bytes end to end through the serial models, across pointer wrap.
        rq.delete();
        for (int i = 0; i < 20; i++) begin
            exp5[i] = 8'(8'h30 + i * 13);
            wr(exp5[i]);
            tick(9);
        end
        tick(80);
        check("t5_rx_count", 32'(rq.size()), 32'd20);
        if (rq.size() == 20)
            for (int i = 0; i < 20; i++) check("t5_pdout", 32'(rq[i]), 32'(exp5[i]));
        check("t5_no_ovf", 32'(bus.Overflow), 32'd0);

        // Write while Full coincides with a pop: still dropped.
        bus.TxEnable = 1'b0;
        for (int i = 0; i < 8; i++) wr(8'(8'h80 + i));
        check("t6_full", 32'(bus.Full), 32'd1);
        sq_cyc.delete();
        sq_data.delete();
        bus.TxEnable = 1'b1;
        wr(8'hEE);
        check("t6_count7", 32'(bus.Count), 32'd7);
        check("t6_ovf", 32'(bus.Overflow), 32'd1);
        check("t6_send", 32'(bus.Send), 32'd1);
        check("t6_pdin", 32'(bus.PDin), 32'h80);
        tick(110);
        check("t6_send_count", 32'(sq_data.size()), 32'd8);
        if (sq_data.size() == 8)
            for (int i = 0; i < 8; i++) check("t6_order", 32'(sq_data[i]), 32'(8'h80 + i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
